// File: rtl/branch_resolve_unit_if.sv
// Predictor-update channel of branch_resolve_unit: valid/ready handshake plus payload.
// The resolve unit drives the master side; the branch predictor is the slave.
interface branch_resolve_unit_if #(
  parameter int ADDR_W = 32
);
  logic              upd_valid;
  logic              upd_ready;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_is_call;
  logic              upd_is_ret;

  modport master (
    output upd_valid, upd_pc, upd_taken, upd_target, upd_is_call, upd_is_ret,
    input  upd_ready
  );

  modport slave (
    input  upd_valid, upd_pc, upd_taken, upd_target, upd_is_call, upd_is_ret,
    output upd_ready
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: oldest-fault/mispredict recovery pulse plus a predictor-update FIFO.
// Optional macro BRU_PERF_CNT_EN adds saturating perf_branches / perf_mispred counters.
module branch_resolve_unit #(
  parameter int LANES  = 2,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic [LANES-1:0]           in_valid,
  input  logic [3*LANES-1:0]         in_op,
  input  logic [ADDR_W*LANES-1:0]    in_opA,
  input  logic [ADDR_W*LANES-1:0]    in_opB,
  input  logic [LANES-1:0]           in_pred_taken,
  input  logic [ADDR_W*LANES-1:0]    in_pred_pc,
  input  logic [ADDR_W*LANES-1:0]    in_jump_pc,
  input  logic [ADDR_W*LANES-1:0]    in_link_pc,
  input  logic [LANES-1:0]           in_is_call,
  input  logic [LANES-1:0]           in_is_ret,
  input  logic [LANES-1:0]           in_ds_exc,
  input  logic [LANES-1:0]           in_ds_ri,
  output logic                       mispredict,
  output logic [ADDR_W-1:0]          recover_pc,
  output logic [$clog2(LANES):0]     mis_lane,
  output logic                       adel,
  output logic [ADDR_W-1:0]          badvaddr,
  branch_resolve_unit_if.master      upd,
  output logic [15:0]                drop_cnt
`ifdef BRU_PERF_CNT_EN
  ,
  output logic [31:0]                perf_branches,
  output logic [31:0]                perf_mispred
`endif
);

  localparam int MW = $clog2(LANES) + 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              taken;
    logic [ADDR_W-1:0] target;
    logic              call;
    logic              ret;
  } upd_t;

  function automatic logic cmp_op(input logic [2:0] op, input logic [ADDR_W-1:0] a,
                                  input logic [ADDR_W-1:0] b);
    logic r;
    case (op)
      3'd0:    r = (a == b);
      3'd1:    r = ($signed(a) >= $signed(b));
      3'd2:    r = ($signed(a) <= $signed(b));
      3'd3:    r = (a != b);
      3'd4:    r = ($signed(a) > $signed(b));
      3'd5:    r = ($signed(a) < $signed(b));
      3'd6:    r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic [LANES-1:0]             res_s, fault_s, wrong_s, squash_s, push_s;
  logic [LANES-1:0][ADDR_W-1:0] tgt_s;
  logic [LANES-1:0][PW-1:0]     slot_s;
  upd_t [LANES-1:0]             ent_s;
  logic                         win_found_s, win_wrong_s, win_fault_s;
  logic [ADDR_W-1:0]            win_tgt_s;
  logic [MW-1:0]                win_idx_s;
  logic                         upd_valid_s, pop_s;
  logic [CW-1:0]                free_s, n_acc_s, n_drop_s;
  logic [16:0]                  drop_sum_s;

  logic                         mispredict_q, mispredict_d, adel_q, adel_d;
  logic [ADDR_W-1:0]            recover_pc_q, recover_pc_d, badvaddr_q, badvaddr_d;
  logic [MW-1:0]                mis_lane_q, mis_lane_d;
  logic [CW-1:0]                count_q, count_d;
  logic [PW-1:0]                wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0]                  drop_q, drop_d;
  upd_t                         mem_q [DEPTH];
  upd_t                         head_s;

  // Per-lane resolution and oldest-winner search; lanes after the winner are squashed.
  always_comb begin
    res_s       = '0;
    fault_s     = '0;
    wrong_s     = '0;
    squash_s    = '0;
    tgt_s       = '0;
    ent_s       = '0;
    win_found_s = 1'b0;
    win_wrong_s = 1'b0;
    win_fault_s = 1'b0;
    win_tgt_s   = '0;
    win_idx_s   = MW'(LANES);
    for (int l = 0; l < LANES; l++) begin
      res_s[l]   = in_valid[l] & cmp_op(in_op[3*l +: 3], in_opA[ADDR_W*l +: ADDR_W],
                                        in_opB[ADDR_W*l +: ADDR_W]);
      tgt_s[l]   = res_s[l] ? in_jump_pc[ADDR_W*l +: ADDR_W] : in_link_pc[ADDR_W*l +: ADDR_W];
      fault_s[l] = in_valid[l] & (tgt_s[l][1:0] != 2'b00);
      wrong_s[l] = in_valid[l] &
                   (((in_pred_taken[l] != res_s[l]) & ~in_ds_exc[l] & ~in_ds_ri[l]) |
                    (in_pred_taken[l] & res_s[l] &
                     (in_pred_pc[ADDR_W*l +: ADDR_W] != in_jump_pc[ADDR_W*l +: ADDR_W])));
      ent_s[l]   = '{pc:     in_link_pc[ADDR_W*l +: ADDR_W] - ADDR_W'(8),
                     taken:  res_s[l],
                     target: in_jump_pc[ADDR_W*l +: ADDR_W],
                     call:   in_is_call[l],
                     ret:    in_is_ret[l]};
      if (win_found_s) begin
        squash_s[l] = 1'b1;
      end else if (fault_s[l] | wrong_s[l]) begin
        win_found_s = 1'b1;
        win_wrong_s = wrong_s[l];
        win_fault_s = fault_s[l];
        win_tgt_s   = tgt_s[l];
        win_idx_s   = MW'(l);
      end else begin
        squash_s[l] = 1'b0;
      end
    end
  end

  assign upd_valid_s = (count_q != '0);
  assign pop_s       = upd_valid_s & upd.upd_ready;
  assign free_s      = CW'(DEPTH) - count_q + CW'(pop_s);

  // Lane-ordered push allocation; eligible lanes that do not fit are dropped youngest-first.
  always_comb begin
    push_s   = '0;
    slot_s   = '0;
    n_acc_s  = '0;
    n_drop_s = '0;
    for (int l = 0; l < LANES; l++) begin
      if (!(in_valid[l] & ~squash_s[l] & ~fault_s[l] & ~in_ds_exc[l] & ~flush)) begin
        push_s[l] = 1'b0;
      end else if (n_acc_s < free_s) begin
        push_s[l] = 1'b1;
        slot_s[l] = n_acc_s[PW-1:0];
        n_acc_s   = n_acc_s + CW'(1);
      end else begin
        n_drop_s  = n_drop_s + CW'(1);
      end
    end
    count_d    = count_q - CW'(pop_s) + n_acc_s;
    wr_ptr_d   = wr_ptr_q + n_acc_s[PW-1:0];
    rd_ptr_d   = rd_ptr_q + PW'(pop_s);
    drop_sum_s = {1'b0, drop_q} + 17'(n_drop_s);
    drop_d     = drop_sum_s[16] ? 16'hFFFF : drop_sum_s[15:0];
  end

  always_comb begin
    mispredict_d = 1'b0;
    adel_d       = 1'b0;
    recover_pc_d = '0;
    badvaddr_d   = '0;
    mis_lane_d   = '0;
    if (!flush) begin
      mispredict_d = win_found_s & win_wrong_s & ~win_fault_s;
      adel_d       = win_fault_s;
      recover_pc_d = win_tgt_s;
      badvaddr_d   = win_tgt_s;
      mis_lane_d   = win_idx_s;
    end else begin
      mis_lane_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mispredict_q <= 1'b0;
      adel_q       <= 1'b0;
      recover_pc_q <= '0;
      badvaddr_q   <= '0;
      mis_lane_q   <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      drop_q       <= '0;
    end else begin
      mispredict_q <= mispredict_d;
      adel_q       <= adel_d;
      recover_pc_q <= recover_pc_d;
      badvaddr_q   <= badvaddr_d;
      mis_lane_q   <= mis_lane_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      drop_q       <= drop_d;
    end
  end

  // Storage needs no reset: only entries between the pointers are ever observed.
  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (push_s[l]) begin
        mem_q[wr_ptr_q + slot_s[l]] <= ent_s[l];
      end
    end
  end

  assign head_s          = upd_valid_s ? mem_q[rd_ptr_q] : '0;
  assign upd.upd_valid   = upd_valid_s;
  assign upd.upd_pc      = head_s.pc;
  assign upd.upd_taken   = head_s.taken;
  assign upd.upd_target  = head_s.target;
  assign upd.upd_is_call = head_s.call;
  assign upd.upd_is_ret  = head_s.ret;

  assign mispredict = mispredict_q;
  assign adel       = adel_q;
  assign recover_pc = recover_pc_q;
  assign badvaddr   = badvaddr_q;
  assign mis_lane   = mis_lane_q;
  assign drop_cnt   = drop_q;

`ifdef BRU_PERF_CNT_EN
  logic [31:0] perf_br_q, perf_mis_q, br_inc_s;
  logic [32:0] br_sum_s;

  always_comb begin
    br_inc_s = '0;
    for (int l = 0; l < LANES; l++) begin
      br_inc_s = br_inc_s + 32'(in_valid[l] & ~squash_s[l]);
    end
    br_sum_s = {1'b0, perf_br_q} + {1'b0, br_inc_s};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_br_q  <= '0;
      perf_mis_q <= '0;
    end else begin
      perf_br_q  <= br_sum_s[32] ? 32'hFFFF_FFFF : br_sum_s[31:0];
      if (mispredict_d && (perf_mis_q != 32'hFFFF_FFFF)) begin
        perf_mis_q <= perf_mis_q + 32'd1;
      end
    end
  end

  assign perf_branches = perf_br_q;
  assign perf_mispred  = perf_mis_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a queue scoreboard on the predictor-update channel.
// Perf-counter checks are compiled in when BRU_PERF_CNT_EN is defined.
module tb_branch_resolve_unit;
  localparam int LANES  = 2;
  localparam int DEPTH  = 4;
  localparam int ADDR_W = 32;

  logic                    clk = 1'b0;
  logic                    resetn, flush;
  logic [LANES-1:0]        in_valid, in_pred_taken, in_is_call, in_is_ret, in_ds_exc, in_ds_ri;
  logic [3*LANES-1:0]      in_op;
  logic [ADDR_W*LANES-1:0] in_opA, in_opB, in_pred_pc, in_jump_pc, in_link_pc;
  logic                    mispredict, adel;
  logic [ADDR_W-1:0]       recover_pc, badvaddr;
  logic [$clog2(LANES):0]  mis_lane;
  logic [15:0]             drop_cnt;
`ifdef BRU_PERF_CNT_EN
  logic [31:0]             perf_branches, perf_mispred;
`endif

  branch_resolve_unit_if #(.ADDR_W(ADDR_W)) upd_bus ();

  branch_resolve_unit #(.LANES(LANES), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .in_valid(in_valid), .in_op(in_op), .in_opA(in_opA), .in_opB(in_opB),
    .in_pred_taken(in_pred_taken), .in_pred_pc(in_pred_pc),
    .in_jump_pc(in_jump_pc), .in_link_pc(in_link_pc),
    .in_is_call(in_is_call), .in_is_ret(in_is_ret),
    .in_ds_exc(in_ds_exc), .in_ds_ri(in_ds_ri),
    .mispredict(mispredict), .recover_pc(recover_pc), .mis_lane(mis_lane),
    .adel(adel), .badvaddr(badvaddr), .upd(upd_bus.master), .drop_cnt(drop_cnt)
`ifdef BRU_PERF_CNT_EN
    , .perf_branches(perf_branches), .perf_mispred(perf_mispred)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic        call;
    logic        ret;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int l, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic pt, input logic [31:0] ppc,
                          input logic [31:0] jpc, input logic [31:0] lpc,
                          input logic call, input logic ret, input logic exc, input logic ri);
    in_valid[l]             = 1'b1;
    in_op[3*l +: 3]         = op;
    in_opA[32*l +: 32]      = a;
    in_opB[32*l +: 32]      = b;
    in_pred_taken[l]        = pt;
    in_pred_pc[32*l +: 32]  = ppc;
    in_jump_pc[32*l +: 32]  = jpc;
    in_link_pc[32*l +: 32]  = lpc;
    in_is_call[l]           = call;
    in_is_ret[l]            = ret;
    in_ds_exc[l]            = exc;
    in_ds_ri[l]             = ri;
  endtask

  task automatic clear_lanes();
    in_valid = '0; in_op = '0; in_opA = '0; in_opB = '0; in_pred_taken = '0;
    in_pred_pc = '0; in_jump_pc = '0; in_link_pc = '0;
    in_is_call = '0; in_is_ret = '0; in_ds_exc = '0; in_ds_ri = '0;
  endtask

  task automatic expect_push(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                             input logic call, input logic ret);
    exp_t e;
    e.pc = pc; e.taken = taken; e.target = tgt; e.call = call; e.ret = ret;
    sb.push_back(e);
  endtask

  // One clock; a handshake that completes at this edge is scored against the queue head.
  task automatic step();
    exp_t e;
    if (upd_bus.upd_valid && upd_bus.upd_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_underflow observed=pop expected=no_pop");
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("upd_pc",      upd_bus.upd_pc,      e.pc);
        chk("upd_taken",   32'(upd_bus.upd_taken),   32'(e.taken));
        chk("upd_target",  upd_bus.upd_target,  e.target);
        chk("upd_is_call", 32'(upd_bus.upd_is_call), 32'(e.call));
        chk("upd_is_ret",  32'(upd_bus.upd_is_ret),  32'(e.ret));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max_cycles);
    int n = 0;
    clear_lanes();
    upd_bus.upd_ready = 1'b1;
    while (sb.size() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    chk("drain_left", 32'(sb.size()), 32'd0);
    chk("drain_valid", 32'(upd_bus.upd_valid), 32'd0);
    upd_bus.upd_ready = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    flush  = 1'b0;
    upd_bus.upd_ready = 1'b0;
    clear_lanes();
    #12;
    chk("rst_mispredict", 32'(mispredict), 32'd0);
    chk("rst_adel",       32'(adel), 32'd0);
    chk("rst_recover_pc", recover_pc, 32'd0);
    chk("rst_mis_lane",   32'(mis_lane), 32'd0);
    chk("rst_upd_valid",  32'(upd_bus.upd_valid), 32'd0);
    chk("rst_drop_cnt",   32'(drop_cnt), 32'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Correctly predicted taken BEQ
    set_lane(0, 3'd0, 32'd5, 32'd5, 1'b1, 32'h1000, 32'h1000, 32'h2008, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_push(32'h2000, 1'b1, 32'h1000, 1'b0, 1'b0);
    step();
    chk("t1_mispredict", 32'(mispredict), 32'd0);
    chk("t1_mis_lane",   32'(mis_lane), 32'd2);
    chk("t1_adel",       32'(adel), 32'd0);
    chk("t1_upd_valid",  32'(upd_bus.upd_valid), 32'd1);
    drain(8);

    // Lane0 BNE mispredicted, lane1 jump squashed
    set_lane(0, 3'd3, 32'd7, 32'd7, 1'b1, 32'h3000, 32'h3000, 32'h4008, 1'b0, 1'b0, 1'b0, 1'b0);
    set_lane(1, 3'd6, 32'd0, 32'd0, 1'b0, 32'h0, 32'h5000, 32'h6008, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_push(32'h4000, 1'b0, 32'h3000, 1'b0, 1'b0);
    step();
    chk("t2_mispredict", 32'(mispredict), 32'd1);
    chk("t2_mis_lane",   32'(mis_lane), 32'd0);
    chk("t2_recover_pc", recover_pc, 32'h4008);
    chk("t2_adel",       32'(adel), 32'd0);
    clear_lanes();
    step();
    chk("t2_pulse_clear", 32'(mispredict), 32'd0);
    chk("t2_lane_none",   32'(mis_lane), 32'd2);
    drain(8);

    // Misaligned jump target raises adel and is not pushed
    set_lane(0, 3'd6, 32'd0, 32'd0, 1'b0, 32'h0, 32'h1002, 32'h7008, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    chk("t3_adel",       32'(adel), 32'd1);
    chk("t3_badvaddr",   badvaddr, 32'h1002);
    chk("t3_recover_pc", recover_pc, 32'h1002);
    chk("t3_mispredict", 32'(mispredict), 32'd0);
    chk("t3_mis_lane",   32'(mis_lane), 32'd0);
    chk("t3_no_push",    32'(upd_bus.upd_valid), 32'd0);
    clear_lanes();
    step();
    chk("t3_adel_clear", 32'(adel), 32'd0);

    // Signed GE / L with call and ret tags
    set_lane(0, 3'd1, 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h0, 32'h100, 32'h208, 1'b1, 1'b0, 1'b0, 1'b0);
    set_lane(1, 3'd5, 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h300, 32'h300, 32'h408, 1'b0, 1'b1, 1'b0, 1'b0);
    expect_push(32'h200, 1'b0, 32'h100, 1'b1, 1'b0);
    expect_push(32'h400, 1'b1, 32'h300, 1'b0, 1'b1);
    step();
    chk("t4_mispredict", 32'(mispredict), 32'd0);
    chk("t4_mis_lane",   32'(mis_lane), 32'd2);
    drain(8);

    // Taken LE with wrong predicted target; lane1 squashed
    set_lane(0, 3'd2, 32'd3, 32'd3, 1'b1, 32'h500, 32'h504, 32'h608, 1'b0, 1'b0, 1'b0, 1'b0);
    set_lane(1, 3'd4, 32'd9, 32'd2, 1'b0, 32'h0, 32'h700, 32'h808, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_push(32'h600, 1'b1, 32'h504, 1'b0, 1'b0);
    step();
    chk("t5_mispredict", 32'(mispredict), 32'd1);
    chk("t5_recover_pc", recover_pc, 32'h504);
    chk("t5_mis_lane",   32'(mis_lane), 32'd0);
    clear_lanes();

    // ds_ri masks the direction miss; ds_exc blocks the push
    set_lane(0, 3'd7, 32'd0, 32'd0, 1'b1, 32'h0, 32'h900, 32'hA08, 1'b0, 1'b0, 1'b0, 1'b1);
    set_lane(1, 3'd7, 32'd0, 32'd0, 1'b0, 32'h0, 32'hB00, 32'hC08, 1'b0, 1'b0, 1'b1, 1'b0);
    expect_push(32'hA00, 1'b0, 32'h900, 1'b0, 1'b0);
    step();
    chk("t6_mispredict", 32'(mispredict), 32'd0);
    chk("t6_mis_lane",   32'(mis_lane), 32'd2);
    clear_lanes();

    // Younger lane wins when the older one is correct
    set_lane(0, 3'd0, 32'd1, 32'd2, 1'b0, 32'h0, 32'hD00, 32'hE08, 1'b0, 1'b0, 1'b0, 1'b0);
    set_lane(1, 3'd6, 32'd0, 32'd0, 1'b0, 32'h0, 32'h800, 32'h908, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_push(32'hE00, 1'b0, 32'hD00, 1'b0, 1'b0);
    expect_push(32'h900, 1'b1, 32'h800, 1'b0, 1'b0);
    step();
    chk("t7_mispredict", 32'(mispredict), 32'd1);
    chk("t7_mis_lane",   32'(mis_lane), 32'd1);
    chk("t7_recover_pc", recover_pc, 32'h800);
    drain(12);

    // Fill with upd_ready low: 6 eligible, 4 stored, 2 dropped
    for (int c = 0; c < 3; c++) begin
      for (int l = 0; l < 2; l++) begin
        set_lane(l, 3'd7, 32'd0, 32'd0, 1'b0, 32'h0, 32'h0,
                 32'h1000 + 32'h10 * (2 * c + l) + 32'h8, 1'b0, 1'b0, 1'b0, 1'b0);
        if (2 * c + l < 4) expect_push(32'h1000 + 32'h10 * (2 * c + l), 1'b0, 32'h0, 1'b0, 1'b0);
      end
      step();
      chk("t8_head_stable", upd_bus.upd_pc, 32'h1000);
    end
    chk("t8_drop_cnt", 32'(drop_cnt), 32'd2);
    chk("t8_valid",    32'(upd_bus.upd_valid), 32'd1);
    // Pop frees one slot: lane0 fits, lane1 dropped
    upd_bus.upd_ready = 1'b1;
    set_lane(0, 3'd7, 32'd0, 32'd0, 1'b0, 32'h0, 32'h0, 32'h1068, 1'b0, 1'b0, 1'b0, 1'b0);
    set_lane(1, 3'd7, 32'd0, 32'd0, 1'b0, 32'h0, 32'h0, 32'h1078, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_push(32'h1060, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    chk("t8_drop_cnt2", 32'(drop_cnt), 32'd3);
    drain(10);

    // Flush kills the mispredict and the push
    set_lane(0, 3'd6, 32'd0, 32'd0, 1'b0, 32'h0, 32'h40, 32'h88, 1'b0, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    clear_lanes();
    chk("t9_mispredict", 32'(mispredict), 32'd0);
    chk("t9_mis_lane",   32'(mis_lane), 32'd0);
    chk("t9_no_push",    32'(upd_bus.upd_valid), 32'd0);
    // Flush leaves stored entries alone
    set_lane(0, 3'd7, 32'd0, 32'd0, 1'b0, 32'h0, 32'h0, 32'h2108, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_push(32'h2100, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    clear_lanes();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("t9_retained", 32'(upd_bus.upd_valid), 32'd1);
    chk("t9_ret_pc",   upd_bus.upd_pc, 32'h2100);
    drain(8);

    // Asynchronous reset in the middle of a drain
    set_lane(0, 3'd7, 32'd0, 32'd0, 1'b0, 32'h0, 32'h0, 32'h3108, 1'b0, 1'b0, 1'b0, 1'b0);
    set_lane(1, 3'd7, 32'd0, 32'd0, 1'b0, 32'h0, 32'h0, 32'h3208, 1'b0, 1'b0, 1'b0, 1'b0);
    expect_push(32'h3100, 1'b0, 32'h0, 1'b0, 1'b0);
    expect_push(32'h3200, 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    clear_lanes();
    upd_bus.upd_ready = 1'b1;
    step();
    #2;
    resetn = 1'b0;
    #1;
    chk("t10_valid",    32'(upd_bus.upd_valid), 32'd0);
    chk("t10_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("t10_mispred",  32'(mispredict), 32'd0);
    sb.delete();
    upd_bus.upd_ready = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;

`ifdef BRU_PERF_CNT_EN
    // 5 cycles x 2 lanes, lane1 mispredicts in three of them, nothing pushed
    for (int c = 0; c < 5; c++) begin
      set_lane(0, 3'd7, 32'd0, 32'd0, 1'b0, 32'h0, 32'h0, 32'h108, 1'b0, 1'b0, 1'b1, 1'b0);
      if (c % 2 == 0)
        set_lane(1, 3'd6, 32'd0, 32'd0, 1'b1, 32'h0, 32'h800, 32'h208, 1'b0, 1'b0, 1'b1, 1'b0);
      else
        set_lane(1, 3'd7, 32'd0, 32'd0, 1'b0, 32'h0, 32'h0, 32'h208, 1'b0, 1'b0, 1'b1, 1'b0);
      step();
    end
    clear_lanes();
    step();
    chk("perf_branches", perf_branches, 32'd10);
    chk("perf_mispred",  perf_mispred, 32'd3);
    chk("perf_no_push",  32'(upd_bus.upd_valid), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
